// File: rtl/lap_stop_watch.sv
// Centisecond stopwatch with edge-detected buttons, saturating run time and a
// browsable LAP_DEPTH-entry lap ring whose newest entry is view index 0.
module lap_stop_watch #(
    parameter int TICKS_PER_CS = 10000,
    parameter int LAP_DEPTH    = 8,
    parameter int IDX_W        = 3,
    parameter bit OVERWRITE    = 1'b1,
    parameter int MIN_MAX      = 99
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_start,
    input  logic             btn_lap,
    input  logic             btn_clear,
    input  logic             btn_older,
    input  logic             btn_newer,
    output logic             running,
    output logic             overflow,
    output logic [6:0]       min,
    output logic [6:0]       sec,
    output logic [6:0]       csec,
    output logic [IDX_W:0]   lap_count,
    output logic             lap_full,
    output logic [IDX_W-1:0] view_idx,
    output logic             view_valid,
    output logic [6:0]       view_min,
    output logic [6:0]       view_sec,
    output logic [6:0]       view_csec
);

    localparam int PW = (TICKS_PER_CS > 32'sd1) ? $clog2(TICKS_PER_CS) : 32'sd1;
    localparam int SW = IDX_W + 32'sd2;
    localparam logic [PW-1:0]    PRESC_LAST = PW'(TICKS_PER_CS - 32'sd1);
    localparam logic [PW-1:0]    PRESC_ONE  = PW'(1'b1);
    localparam logic [IDX_W:0]   DEPTH_C    = (IDX_W+1)'(LAP_DEPTH);
    localparam logic [IDX_W:0]   CNT_ONE    = (IDX_W+1)'(1'b1);
    localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1'b1);
    localparam logic [IDX_W-1:0] PTR_LAST   = IDX_W'(LAP_DEPTH - 32'sd1);
    localparam logic [SW-1:0]    RD_OFS     = SW'(LAP_DEPTH - 32'sd1);
    localparam logic [SW-1:0]    DEPTH_W    = SW'(LAP_DEPTH);
    localparam logic [6:0]       MIN_LAST   = 7'(MIN_MAX);

    logic [4:0]       btn_s, btn_q_r, edge_s;
    logic             armed_r;
    logic [PW-1:0]    presc_r;
    logic             running_r, overflow_r;
    logic [6:0]       min_r, sec_r, csec_r;
    logic [6:0]       min_n_s, sec_n_s, csec_n_s;
    logic [20:0]      lap_mem_r [LAP_DEPTH];
    logic [IDX_W-1:0] wr_ptr_r, view_idx_r, wr_ptr_n_s, view_idx_n_s, rd_ptr_s;
    logic [IDX_W:0]   lap_count_r, lap_count_n_s;
    logic [SW-1:0]    rd_sum_s;
    logic [20:0]      rd_data_s;
    logic             lap_full_r, view_valid_r;
    logic [6:0]       view_min_r, view_sec_r, view_csec_r;
    logic             clear_fire_s, start_fire_s, lap_fire_s, older_fire_s, newer_fire_s;
    logic             has_laps_s, full_s, lap_store_s, tick_s, at_max_s, saturate_s;

    // The edge register is loaded on the first clock after reset without firing.
    assign btn_s  = {btn_newer, btn_older, btn_clear, btn_lap, btn_start};
    assign edge_s = btn_s & ~btn_q_r & {5{armed_r}};

    assign has_laps_s  = (lap_count_r != '0);
    assign full_s      = (lap_count_r == DEPTH_C);
    assign tick_s      = running_r && (presc_r == PRESC_LAST);
    assign at_max_s    = (min_r == MIN_LAST) && (sec_r == 7'd59) && (csec_r == 7'd99);
    assign saturate_s  = tick_s && at_max_s;
    assign lap_store_s = lap_fire_s && (!full_s || OVERWRITE);

    // Single-winner action arbitration: clear > start > lap > older > newer.
    always_comb begin
        clear_fire_s = 1'b0;
        start_fire_s = 1'b0;
        lap_fire_s   = 1'b0;
        older_fire_s = 1'b0;
        newer_fire_s = 1'b0;
        if (edge_s[2] && !running_r) begin
            clear_fire_s = 1'b1;
        end else if (edge_s[0] && !overflow_r) begin
            start_fire_s = 1'b1;
        end else if (edge_s[1] && running_r) begin
            lap_fire_s = 1'b1;
        end else if (edge_s[3] && has_laps_s) begin
            older_fire_s = 1'b1;
        end else if (edge_s[4] && has_laps_s) begin
            newer_fire_s = 1'b1;
        end else begin
            clear_fire_s = 1'b0;
        end
    end

    // Next live time: csec/sec/min carry chain, frozen at the saturation point.
    always_comb begin
        min_n_s  = min_r;
        sec_n_s  = sec_r;
        csec_n_s = csec_r;
        if (clear_fire_s) begin
            min_n_s  = 7'd0;
            sec_n_s  = 7'd0;
            csec_n_s = 7'd0;
        end else if (tick_s && !at_max_s) begin
            if (csec_r == 7'd99) begin
                csec_n_s = 7'd0;
                if (sec_r == 7'd59) begin
                    sec_n_s = 7'd0;
                    min_n_s = min_r + 7'd1;
                end else begin
                    sec_n_s = sec_r + 7'd1;
                end
            end else begin
                csec_n_s = csec_r + 7'd1;
            end
        end else begin
            csec_n_s = csec_r;
        end
    end

    // Next lap bookkeeping: count, write pointer and browse index.
    always_comb begin
        lap_count_n_s = lap_count_r;
        wr_ptr_n_s    = wr_ptr_r;
        view_idx_n_s  = view_idx_r;
        if (clear_fire_s) begin
            lap_count_n_s = '0;
            wr_ptr_n_s    = '0;
            view_idx_n_s  = '0;
        end else if (lap_store_s) begin
            wr_ptr_n_s   = (wr_ptr_r == PTR_LAST) ? '0 : (wr_ptr_r + IDX_ONE);
            view_idx_n_s = '0;
            if (!full_s) begin
                lap_count_n_s = lap_count_r + CNT_ONE;
            end else begin
                lap_count_n_s = lap_count_r;
            end
        end else if (older_fire_s) begin
            if (({1'b0, view_idx_r} + CNT_ONE) < lap_count_r) begin
                view_idx_n_s = view_idx_r + IDX_ONE;
            end else begin
                view_idx_n_s = view_idx_r;
            end
        end else if (newer_fire_s) begin
            if (view_idx_r != '0) begin
                view_idx_n_s = view_idx_r - IDX_ONE;
            end else begin
                view_idx_n_s = view_idx_r;
            end
        end else begin
            view_idx_n_s = view_idx_r;
        end
    end

    // Viewed entry is (wr_ptr - 1 - view_idx) mod LAP_DEPTH, valid for any depth.
    always_comb begin
        rd_sum_s = SW'(wr_ptr_r) + RD_OFS - SW'(view_idx_r);
        if (rd_sum_s >= DEPTH_W) begin
            rd_ptr_s = IDX_W'(rd_sum_s - DEPTH_W);
        end else begin
            rd_ptr_s = IDX_W'(rd_sum_s);
        end
    end

    assign rd_data_s = lap_mem_r[rd_ptr_s];

    // Lap storage; stale contents are masked by lap_count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (lap_store_s) begin
            lap_mem_r[wr_ptr_r] <= {min_r, sec_r, csec_r};
        end
    end

    // Control, time, lap bookkeeping and registered view state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_q_r      <= 5'b00000;
            armed_r      <= 1'b0;
            presc_r      <= '0;
            running_r    <= 1'b0;
            overflow_r   <= 1'b0;
            min_r        <= 7'd0;
            sec_r        <= 7'd0;
            csec_r       <= 7'd0;
            lap_count_r  <= '0;
            wr_ptr_r     <= '0;
            view_idx_r   <= '0;
            lap_full_r   <= 1'b0;
            view_valid_r <= 1'b0;
            view_min_r   <= 7'd0;
            view_sec_r   <= 7'd0;
            view_csec_r  <= 7'd0;
        end else begin
            btn_q_r <= btn_s;
            armed_r <= 1'b1;
            min_r   <= min_n_s;
            sec_r   <= sec_n_s;
            csec_r  <= csec_n_s;
            if (clear_fire_s) begin
                presc_r <= '0;
            end else if (running_r) begin
                presc_r <= (presc_r == PRESC_LAST) ? '0 : (presc_r + PRESC_ONE);
            end
            if (clear_fire_s) begin
                overflow_r <= 1'b0;
            end else if (saturate_s) begin
                overflow_r <= 1'b1;
            end
            if (saturate_s) begin
                running_r <= 1'b0;
            end else if (start_fire_s) begin
                running_r <= ~running_r;
            end
            lap_count_r  <= lap_count_n_s;
            wr_ptr_r     <= wr_ptr_n_s;
            view_idx_r   <= view_idx_n_s;
            lap_full_r   <= (lap_count_n_s == DEPTH_C);
            view_valid_r <= (lap_count_n_s != '0);
            if (clear_fire_s || !has_laps_s) begin
                view_min_r  <= 7'd0;
                view_sec_r  <= 7'd0;
                view_csec_r <= 7'd0;
            end else begin
                {view_min_r, view_sec_r, view_csec_r} <= rd_data_s;
            end
        end
    end

    assign running    = running_r;
    assign overflow   = overflow_r;
    assign min        = min_r;
    assign sec        = sec_r;
    assign csec       = csec_r;
    assign lap_count  = lap_count_r;
    assign lap_full   = lap_full_r;
    assign view_idx   = view_idx_r;
    assign view_valid = view_valid_r;
    assign view_min   = view_min_r;
    assign view_sec   = view_sec_r;
    assign view_csec  = view_csec_r;

endmodule

// File: tb/tb_lap_stop_watch.sv
// Two lap_stop_watch instances (OVERWRITE=0 and 1) share one button stream;
// per-instance models push expected states that a monitor pops and compares.
module tb_lap_stop_watch;

    localparam int TICKS = 2;
    localparam int DEPTH = 4;
    localparam int MINMX = 1;
    localparam int TMAX  = MINMX * 6000 + 5999;

    localparam logic [4:0] B_START = 5'b00001;
    localparam logic [4:0] B_LAP   = 5'b00010;
    localparam logic [4:0] B_CLEAR = 5'b00100;
    localparam logic [4:0] B_OLDER = 5'b01000;

    typedef struct {
        int run;
        int ovf;
        int t;
        int cnt;
        int vidx;
        int view;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [4:0] btn;

    logic       running_v [2];
    logic       overflow_v [2];
    logic       lap_full_v [2];
    logic       view_valid_v [2];
    logic [6:0] min_v [2];
    logic [6:0] sec_v [2];
    logic [6:0] csec_v [2];
    logic [6:0] vmin_v [2];
    logic [6:0] vsec_v [2];
    logic [6:0] vcsec_v [2];
    logic [2:0] cnt_v [2];
    logic [1:0] vidx_v [2];

    int n_checks = 0;
    int n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : ch
        localparam bit OV = (g == 1);

        lap_stop_watch #(
            .TICKS_PER_CS(TICKS), .LAP_DEPTH(DEPTH), .IDX_W(2),
            .OVERWRITE(OV), .MIN_MAX(MINMX)
        ) dut (
            .clk(clk), .rst(rst),
            .btn_start(btn[0]), .btn_lap(btn[1]), .btn_clear(btn[2]),
            .btn_older(btn[3]), .btn_newer(btn[4]),
            .running(running_v[g]), .overflow(overflow_v[g]),
            .min(min_v[g]), .sec(sec_v[g]), .csec(csec_v[g]),
            .lap_count(cnt_v[g]), .lap_full(lap_full_v[g]),
            .view_idx(vidx_v[g]), .view_valid(view_valid_v[g]),
            .view_min(vmin_v[g]), .view_sec(vsec_v[g]), .view_csec(vcsec_v[g])
        );

        // Reference state: total centiseconds plus a newest-first lap list.
        int         m_t, m_pre, m_vidx, m_view, m_n, m_told;
        bit         m_run, m_ovf, m_armed, m_runold;
        logic [4:0] m_prev, m_e;
        int         m_laps[$];
        exp_t       m_q[$];
        exp_t       m_x;

        initial forever begin
            @(posedge clk);
            if (rst) begin
                m_t = 0; m_pre = 0; m_vidx = 0; m_view = 0;
                m_run = 1'b0; m_ovf = 1'b0; m_armed = 1'b0; m_prev = 5'b0;
                m_laps.delete();
            end else begin
                m_e     = m_armed ? (btn & ~m_prev) : 5'b0;
                m_prev  = btn;
                m_armed = 1'b1;
                m_n     = m_laps.size();
                m_view  = (m_n == 0) ? 0 : m_laps[m_vidx];
                m_told  = m_t;
                m_runold = m_run;
                if (m_e[2] && !m_runold) begin
                    m_t = 0; m_pre = 0; m_ovf = 1'b0; m_vidx = 0; m_view = 0;
                    m_laps.delete();
                end else begin
                    if (m_runold) begin
                        if (m_pre == TICKS - 1) begin
                            m_pre = 0;
                            if (m_t == TMAX) begin
                                m_ovf = 1'b1;
                                m_run = 1'b0;
                            end else begin
                                m_t++;
                            end
                        end else begin
                            m_pre++;
                        end
                    end
                    if (m_e[0] && !m_ovf) begin
                        m_run = !m_runold;
                    end else if (m_e[1] && m_runold) begin
                        if (m_n < DEPTH) begin
                            m_laps.push_front(m_told);
                            m_vidx = 0;
                        end else if (OV) begin
                            void'(m_laps.pop_back());
                            m_laps.push_front(m_told);
                            m_vidx = 0;
                        end
                    end else if (m_e[3] && m_n != 0) begin
                        if (m_vidx < m_n - 1) m_vidx++;
                    end else if (m_e[4] && m_n != 0) begin
                        if (m_vidx > 0) m_vidx--;
                    end
                end
                m_q.push_back('{run: int'(m_run), ovf: int'(m_ovf), t: m_t,
                                cnt: m_laps.size(), vidx: m_vidx, view: m_view});
            end
        end

        // Monitor: every presented state is checked against the oldest expectation.
        initial forever begin
            @(posedge clk);
            #1;
            if (m_q.size() != 0) begin
                m_x = m_q.pop_front();
                n_checks++;
                if (int'(running_v[g]) != m_x.run || int'(overflow_v[g]) != m_x.ovf ||
                    int'(min_v[g]) != m_x.t / 6000 || int'(sec_v[g]) != (m_x.t / 100) % 60 ||
                    int'(csec_v[g]) != m_x.t % 100 || int'(cnt_v[g]) != m_x.cnt ||
                    int'(lap_full_v[g]) != int'(m_x.cnt == DEPTH) ||
                    int'(view_valid_v[g]) != int'(m_x.cnt != 0) ||
                    int'(vidx_v[g]) != m_x.vidx || int'(vmin_v[g]) != m_x.view / 6000 ||
                    int'(vsec_v[g]) != (m_x.view / 100) % 60 || int'(vcsec_v[g]) != m_x.view % 100) begin
                    n_errors++;
                    $display("FAIL state_ov%0d @%0t: got run=%0d ovf=%0d time=%0d:%0d.%0d cnt=%0d full=%0d idx=%0d vv=%0d view=%0d:%0d.%0d; expected run=%0d ovf=%0d t_cs=%0d cnt=%0d idx=%0d view_cs=%0d",
                             g, $time, running_v[g], overflow_v[g], min_v[g], sec_v[g], csec_v[g],
                             cnt_v[g], lap_full_v[g], vidx_v[g], view_valid_v[g],
                             vmin_v[g], vsec_v[g], vcsec_v[g],
                             m_x.run, m_x.ovf, m_x.t, m_x.cnt, m_x.vidx, m_x.view);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic [4:0] m);
        btn = m;
        @(negedge clk);
        btn = 5'b0;
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string name);
        for (int g = 0; g < 2; g++) begin
            check({name, "_running"}, int'(running_v[g]), 0);
            check({name, "_time"}, int'({min_v[g], sec_v[g], csec_v[g]}), 0);
            check({name, "_count"}, int'(cnt_v[g]), 0);
            check({name, "_view"}, int'({vidx_v[g], view_valid_v[g], vmin_v[g], vsec_v[g], vcsec_v[g]}), 0);
            check({name, "_flags"}, int'({overflow_v[g], lap_full_v[g]}), 0);
        end
    endtask

    initial begin
        btn = 5'b0;
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        idle(2);

        // Run for one second, stop, freeze, held start toggles once.
        pulse(B_START);
        idle(199);
        for (int g = 0; g < 2; g++) begin
            check("run_1s_min", int'(min_v[g]), 0);
            check("run_1s_sec", int'(sec_v[g]), 1);
            check("run_1s_csec", int'(csec_v[g]), 0);
            check("run_1s_running", int'(running_v[g]), 1);
        end
        pulse(B_START);
        idle(50);
        for (int g = 0; g < 2; g++) begin
            check("stop_running", int'(running_v[g]), 0);
            check("stop_frozen", int'(sec_v[g]) * 100 + int'(csec_v[g]), 100);
        end
        btn = B_START;
        idle(20);
        btn = 5'b0;
        idle(1);
        for (int g = 0; g < 2; g++) check("held_start_once", int'(running_v[g]), 1);
        pulse(B_START);

        // Laps at 0:00.10, 0:00.25, 0:00.40 and browsing.
        pulse(B_CLEAR);
        pulse(B_START);
        idle(19);
        pulse(B_LAP);
        idle(28);
        pulse(B_LAP);
        idle(28);
        pulse(B_LAP);
        for (int g = 0; g < 2; g++) begin
            check("lap3_count", int'(cnt_v[g]), 3);
            check("lap3_idx", int'(vidx_v[g]), 0);
            check("lap3_view", int'(vsec_v[g]) * 100 + int'(vcsec_v[g]), 40);
        end
        pulse(B_START);
        pulse(B_OLDER);
        pulse(B_OLDER);
        for (int g = 0; g < 2; g++) begin
            check("older2_idx", int'(vidx_v[g]), 2);
            check("older2_view", int'(vsec_v[g]) * 100 + int'(vcsec_v[g]), 10);
        end
        pulse(B_OLDER);
        for (int g = 0; g < 2; g++) check("older_sat_idx", int'(vidx_v[g]), 2);

        // Six laps at csec 1..6 into a four-entry ring.
        pulse(B_CLEAR);
        pulse(B_START);
        idle(1);
        repeat (6) pulse(B_LAP);
        pulse(B_START);
        for (int g = 0; g < 2; g++) begin
            check("ring_count", int'(cnt_v[g]), 4);
            check("ring_full", int'(lap_full_v[g]), 1);
        end
        for (int i = 0; i < 4; i++) begin
            check("ring_view_ov1", int'(vsec_v[1]) * 100 + int'(vcsec_v[1]), 6 - i);
            check("ring_view_ov0", int'(vsec_v[0]) * 100 + int'(vcsec_v[0]), 4 - i);
            pulse(B_OLDER);
        end

        // Ignored actions and priority.
        pulse(B_LAP);
        for (int g = 0; g < 2; g++) check("lap_stopped_ignored", int'(cnt_v[g]), 4);
        pulse(B_START);
        pulse(B_CLEAR);
        for (int g = 0; g < 2; g++) begin
            check("clear_running_ignored", int'(cnt_v[g]), 4);
            check("clear_running_still", int'(running_v[g]), 1);
        end
        pulse(B_START);
        pulse(B_CLEAR | B_START | B_LAP);
        for (int g = 0; g < 2; g++) begin
            check("prio_running", int'(running_v[g]), 0);
            check("prio_count", int'(cnt_v[g]), 0);
            check("prio_time", int'(sec_v[g]) * 100 + int'(csec_v[g]), 0);
        end

        // Lap coinciding with the tick leaving 0:00.09.
        pulse(B_START);
        idle(18);
        pulse(B_LAP);
        pulse(B_START);
        for (int g = 0; g < 2; g++) begin
            check("tick_lap_count", int'(cnt_v[g]), 1);
            check("tick_lap_view", int'(vsec_v[g]) * 100 + int'(vcsec_v[g]), 9);
        end

        // Saturation at 1:59.99.
        pulse(B_CLEAR);
        pulse(B_START);
        idle(24010);
        for (int g = 0; g < 2; g++) begin
            check("sat_overflow", int'(overflow_v[g]), 1);
            check("sat_running", int'(running_v[g]), 0);
            check("sat_time", int'(min_v[g]) * 6000 + int'(sec_v[g]) * 100 + int'(csec_v[g]), TMAX);
        end
        pulse(B_START);
        for (int g = 0; g < 2; g++) check("sat_start_ignored", int'(running_v[g]), 0);
        pulse(B_CLEAR);
        check_all_zero("sat_clear");

        // Asynchronous reset mid-run with lap held through deassertion.
        pulse(B_START);
        idle(30);
        btn = B_LAP;
        idle(5);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        idle(2);
        rst = 1'b0;
        idle(3);
        for (int g = 0; g < 2; g++) check("held_lap_after_rst", int'(cnt_v[g]), 0);
        btn = 5'b0;
        idle(2);

        // Random button traffic against the models.
        for (int i = 0; i < 4000; i++) begin
            for (int k = 0; k < 5; k++) btn[k] = ($urandom_range(0, 5) == 0);
            @(negedge clk);
        end
        btn = 5'b0;
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lap_stop_watch.md
Name: lap_stop_watch

Overview:
- Parametrised successor to the single-channel stopwatch.
- Centisecond stopwatch with an internal prescaler, edge-detected start/stop, lap and clear buttons, and a LAP_DEPTH-entry lap memory.
- The lap memory is browsable: newest entry first.
- Sits beside the existing stopwatch/timer blocks under the watch top level; its min/sec/csec outputs feed the sep/sep4 digit splitters and the VFD line builder.

Parameters:
TICKS_PER_CS, 10000, clk cycles per 1/100 s (prescaler terminal count; benches use 2)
LAP_DEPTH, 8, number of stored laps (>=2)
IDX_W, 3, lap index width, >= clog2(LAP_DEPTH)
OVERWRITE, 1, 1 = ring overwrites oldest lap when full; 0 = new laps dropped when full
MIN_MAX, 99, highest minute value before saturation

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high; clears all state immediately
btn_start  in  1  level button; rising edge toggles run/stop
btn_lap  in  1  level button; rising edge captures lap while running
btn_clear  in  1  level button; rising edge clears time and laps while stopped
btn_older  in  1  level button; rising edge moves view to older lap
btn_newer  in  1  level button; rising edge moves view to newer lap
running  out  1  1 while counting
overflow  out  1  set when time saturates at MIN_MAX:59.99
min  out  7  live minutes, 0..MIN_MAX
sec  out  7  live seconds, 0..59
csec  out  7  live centiseconds, 0..99
lap_count  out  IDX_W+1  stored laps, 0..LAP_DEPTH
lap_full  out  1  lap_count == LAP_DEPTH
view_idx  out  IDX_W  0 = newest lap
view_valid  out  1  lap_count != 0
view_min  out  7  minutes of the viewed lap
view_sec  out  7  seconds of the viewed lap
view_csec  out  7  centiseconds of the viewed lap

Behaviour:
- Reset: all outputs and internal state are 0, including the prescaler, edge registers, lap memory pointers and the view registers.
- Buttons:
  - Each button is registered once.
  - An action fires in the cycle where the current level is 1 and the registered level is 0, so one action per press.
  - Held buttons never repeat.
- Simultaneous edges, priority: clear > start > lap > older/newer. Only the highest-priority valid action fires; lower ones are discarded.
- Prescaler:
  - Counts 0..TICKS_PER_CS-1 only while running.
  - Holds its value when stopped.
  - Zeroed by clear.
  - At the terminal count it wraps to 0 and time advances by 1 cs in the same cycle.
- Time advance:
  - csec 99->0 carries into sec.
  - sec 59->0 carries into min.
  - At MIN_MAX:59.99 a tick does not wrap. Time holds, overflow goes to 1 and running goes to 0 in that cycle.
  - Start is ignored while overflow=1; only clear removes it.
- Start edge: running toggles the next cycle. Stop-then-start resumes from the held time and prescaler.
- Lap edge:
  - Valid only while running; ignored while stopped.
  - Stores the min/sec/csec register values of the edge cycle, i.e. the pre-tick value if a tick coincides.
  - Written at the write pointer; the pointer advances modulo LAP_DEPTH.
  - lap_count increments, saturating at LAP_DEPTH.
  - When full with OVERWRITE=1, the oldest entry is replaced; lap_count stays LAP_DEPTH.
  - When full with OVERWRITE=0, the lap is dropped and memory is unchanged.
  - Every accepted lap sets view_idx to 0.
- Browse:
  - older: view_idx+1, saturating at lap_count-1.
  - newer: view_idx-1, saturating at 0.
  - Both do nothing while lap_count==0.
  - Allowed while running or stopped.
- View data:
  - Registered. view_min/sec/csec reflect entry (wr_ptr-1-view_idx) mod LAP_DEPTH one cycle after any change of view_idx or of the memory.
  - Forced to 0 when lap_count==0.
- Clear edge:
  - Valid only while stopped; ignored while running.
  - Zeros time, prescaler, overflow, lap_count, pointers, view_idx and view data.
  - Memory contents need not be zeroed, but must be unobservable.
- rst asserted mid-count or mid-press returns every output to 0 asynchronously. A button held through rst deassertion does not fire, because the edge register is loaded with the level on the first clock after reset.

Test Plan:
- Run/stop, TICKS_PER_CS=2: rst, pulse start, wait 200 clk -> min=0 sec=1 csec=0, running=1. Pulse start -> running=0, time frozen for 50 clk. Hold start 20 clk -> exactly one toggle.
- Carry and saturation, MIN_MAX=1, TICKS_PER_CS=2: run to 1:59.99, then 2 more clk -> time stays 1:59.99, overflow=1, running=0. Start pulse -> no change. Clear -> all zero, overflow=0.
- Lap capture: laps at 0:00.10, 0:00.25, 0:00.40 -> lap_count=3, view_idx=0, view 0:00.40 after 1 clk. Two older pulses -> view_idx=2, view 0:00.10. Third older -> idx stays 2.
- Full ring, LAP_DEPTH=4, OVERWRITE=1: 6 laps at csec 1..6 -> lap_count=4, lap_full=1, views idx0..3 = 6,5,4,3. With OVERWRITE=0 -> views 4,3,2,1.
- Priority and ignores:
  - Lap while stopped -> no store.
  - Clear while running -> no change.
  - Clear, start and lap edges in the same cycle while stopped -> only clear acts; running stays 0.
  - Lap edge coinciding with a tick at 0:00.09 -> stores 0:00.09.
- Async reset mid-run with btn_lap held: assert rst between clock edges -> outputs 0 before the next clk. Deassert rst with btn_lap still held -> no lap is stored, lap_count=0.
